// File: rtl/mux_4to1_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mux_4to1_pkg
// Brief   : Shared lane-count and select-width constants for mux_4to1.
// Revision: 1.0
// ============================================================================
package mux_4to1_pkg;

    localparam int NUM_LANES = 4;
    localparam int SEL_W     = 2;

endpackage : mux_4to1_pkg
`default_nettype wire

// File: rtl/mux_4to1_reg.sv
`default_nettype none
// ============================================================================
// Module  : mux_4to1_reg
// Brief   : DW-wide D flop, asynchronous active-low reset to RST_VAL.
// Revision: 1.0
// ============================================================================
module mux_4to1_reg #(
    parameter int          DW      = 1,
    parameter logic [DW-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    logic [DW-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= RST_VAL;
        end else begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule : mux_4to1_reg
`default_nettype wire

// File: rtl/mux_4to1.sv
`default_nettype none
// ============================================================================
// Module  : mux_4to1
// Brief   : 4-lane mux with enable; combinational z1 plus registered z1_q.
// Revision: 1.0
// ============================================================================
module mux_4to1
    import mux_4to1_pkg::*;
#(
    parameter int            DW      = 1,
    parameter logic [DW-1:0] RST_VAL = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_LANES*DW-1:0] d,
    input  logic [SEL_W-1:0]       s,
    input  logic                   enbl,
    output logic [DW-1:0]          z1,
    output logic [DW-1:0]          z1_q
);

    logic [DW-1:0] w_z1;

    // Indexed part-select lets an unknown select propagate as X in simulation.
    always_comb begin
        w_z1 = '0;
        if (enbl) begin
            w_z1 = d[s*DW +: DW];
        end
    end

    assign z1 = w_z1;

    mux_4to1_reg #(
        .DW      (DW),
        .RST_VAL (RST_VAL)
    ) u_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (w_z1),
        .q     (z1_q)
    );

endmodule : mux_4to1
`default_nettype wire

// File: tb/tb_mux_4to1.sv
`default_nettype none
// ============================================================================
// Module  : tb_mux_4to1
// Brief   : Self-checking bench for mux_4to1 (DW=1) against a behavioural model.
// Revision: 1.0
// ============================================================================
module tb_mux_4to1;

    logic       clk;
    logic       rst_n;
    logic [3:0] d;
    logic [1:0] s;
    logic       enbl;
    logic       z1;
    logic       z1_q;

    int n_cmp  = 0;
    int n_fail = 0;

    mux_4to1 #(
        .DW      (1),
        .RST_VAL (1'b0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (d),
        .s     (s),
        .enbl  (enbl),
        .z1    (z1),
        .z1_q  (z1_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: selected lane is bit number s of d, gated by enable.
    function automatic logic ref_z1(input logic e, input logic [1:0] sel, input logic [3:0] data);
        int v;
        v = e ? ((int'(data) >> int'(sel)) & 1) : 0;
        return logic'(v[0]);
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive between edges, check z1 at once, then z1_q just after the next rising edge.
    task automatic step(input string tag, input logic e, input logic [1:0] sv, input logic [3:0] dv);
        logic exp;
        @(negedge clk);
        enbl = e;
        s    = sv;
        d    = dv;
        #1;
        exp = ref_z1(e, sv, dv);
        check({tag, ".z1"}, z1, exp);
        @(posedge clk);
        #1;
        check({tag, ".z1_q"}, z1_q, rst_n ? exp : 1'b0);
    endtask

    initial begin
        rst_n = 1'b1;
        enbl  = 1'b1;
        s     = 2'b11;
        d     = 4'b1111;

        // Asynchronous reset before any clock edge has occurred.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_no_edge", z1_q, 1'b0);
        check("z1_in_reset", z1, 1'b1);

        step("t1a", 1'b1, 2'b00, 4'b1010);
        step("t1b", 1'b1, 2'b00, 4'b1011);
        step("t2a", 1'b1, 2'b01, 4'b1011);
        step("t2b", 1'b1, 2'b10, 4'b1011);
        step("t2c", 1'b1, 2'b11, 4'b1011);
        step("t3a", 1'b1, 2'b01, 4'b1001);
        step("t3b", 1'b1, 2'b11, 4'b0011);
        step("t4a", 1'b0, 2'b11, 4'b1111);

        // Enable rises with nothing else changing: z1 follows without a clock edge.
        enbl = 1'b1;
        #1;
        check("t4b.z1", z1, 1'b1);

        // Release reset between edges; first load happens on the next rising edge.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel.before_edge", z1_q, 1'b0);
        @(posedge clk);
        #1;
        check("rel.first_load", z1_q, 1'b1);

        for (int i = 0; i < 64; i++) begin
            logic [5:0] v;
            v = 6'(i);
            step("sweep", v[5], v[4:3] == 2'b00 ? v[1:0] : v[4:3], v[3:0]);
        end
        for (int i = 0; i < 64; i++) begin
            logic [5:0] v;
            v = 6'(i);
            step("sweep2", v[5], v[5:4], v[3:0]);
        end

        for (int i = 0; i < 100; i++) begin
            step("rand", 1'($urandom), 2'($urandom), 4'($urandom));
        end

        // Mid-run reset: z1_q clears immediately, z1 keeps tracking.
        step("mid.load", 1'b1, 2'b10, 4'b0100);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid.z1_q_clear", z1_q, 1'b0);
        check("mid.z1_track", z1, 1'b1);
        step("mid.held", 1'b1, 2'b00, 4'b0001);
        step("mid.held2", 1'b0, 2'b11, 4'b1000);

        @(negedge clk);
        rst_n = 1'b1;
        step("post.rst", 1'b1, 2'b11, 4'b1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_mux_4to1
`default_nettype wire
